// File: rtl/alu_share_if.sv
// alu_share_if: request, ALU-side and response signals of the shared-ALU arbiter
interface alu_share_if #(parameter int WIDTH = 32);
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]       req0_aluop, req1_aluop;
  logic [3:0]       req0_func, req1_func;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             flush;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero;
  logic             resp_valid, resp_id, resp_zero, resp_err;
  logic [WIDTH-1:0] resp_data;
  modport slave (
    input  req0_valid, req0_aluop, req0_func, req0_a, req0_b,
    input  req1_valid, req1_aluop, req1_func, req1_a, req1_b,
    input  flush, alu_result, alu_zero,
    output req0_ready, req1_ready, alu_ctl, alu_a, alu_b,
    output resp_valid, resp_id, resp_data, resp_zero, resp_err
  );
  modport master (
    output req0_valid, req0_aluop, req0_func, req0_a, req0_b,
    output req1_valid, req1_aluop, req1_func, req1_a, req1_b,
    output flush, alu_result, alu_zero,
    input  req0_ready, req1_ready, alu_ctl, alu_a, alu_b,
    input  resp_valid, resp_id, resp_data, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: arbitrates two requesters onto one ALU, decodes ALUOp/FuncCode,
// and returns tagged results through a grant -> issue/capture pipeline
module alu_share_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 3
) (
  input logic        clk,
  input logic        rst_n,
  alu_share_if.slave bus
);
  logic [3:0]       cnt, dctl, fn;
  logic [1:0]       op;
  logic [WIDTH-1:0] ga, gb;
  logic             override, grant, gid, derr, issue, capture;
  logic             issue_valid, issue_id, issue_err;
  assign override       = bus.req1_valid && (cnt >= 4'(STARVE_LIMIT));
  assign bus.req1_ready = bus.req1_valid && (!bus.req0_valid || override);
  assign bus.req0_ready = bus.req0_valid && !override;
  assign grant          = bus.req0_ready || bus.req1_ready;
  assign gid            = bus.req1_ready;
  // A flushed port-0 grant is consumed by the handshake but never issued
  assign issue          = grant && !(bus.flush && !gid);
  assign capture        = issue_valid && !(bus.flush && !issue_id);
  always_comb begin
    op   = gid ? bus.req1_aluop : bus.req0_aluop;
    fn   = gid ? bus.req1_func  : bus.req0_func;
    ga   = gid ? bus.req1_a     : bus.req0_a;
    gb   = gid ? bus.req1_b     : bus.req0_b;
    derr = op[1] && !(fn inside {4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b1100});
    dctl = op == 2'b00   ? 4'b0010 :
           op == 2'b01   ? 4'b0110 :
           fn == 4'b1000 ? 4'b0110 :
           fn == 4'b0111 ? 4'b0000 :
           fn == 4'b0110 ? 4'b0001 :
           fn == 4'b1100 ? 4'b0111 : 4'b0010;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 4'd0;
    else if (!bus.req1_valid || bus.req1_ready) cnt <= 4'd0;
    else if (cnt != 4'hF) cnt <= cnt + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_ctl <= 4'b0000;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      issue_valid <= 1'b0;
      issue_id    <= 1'b0;
      issue_err   <= 1'b0;
    end else begin
      issue_valid <= issue;
      if (issue) begin
        if (!derr) bus.alu_ctl <= dctl;
        bus.alu_a <= ga;
        bus.alu_b <= gb;
        issue_id  <= gid;
        issue_err <= derr;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_zero  <= 1'b0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= capture;
      if (capture) begin
        bus.resp_id   <= issue_id;
        bus.resp_err  <= issue_err;
        bus.resp_data <= issue_err ? '0 : bus.alu_result;
        bus.resp_zero <= !issue_err && bus.alu_zero;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vector table plus reset, pipeline, starvation and flush sequences
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  alu_share_if #(.WIDTH(32)) bus();
  alu_share_arbiter #(.WIDTH(32), .STARVE_LIMIT(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.alu_result = bus.alu_ctl == 4'b0010 ? bus.alu_a + bus.alu_b :
                     bus.alu_ctl == 4'b0110 ? bus.alu_a - bus.alu_b :
                     bus.alu_ctl == 4'b0000 ? bus.alu_a & bus.alu_b :
                     bus.alu_ctl == 4'b0001 ? bus.alu_a | bus.alu_b :
                     bus.alu_ctl == 4'b0111 ? {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)} : 32'd0;
    bus.alu_zero   = bus.alu_result == 32'd0;
  end
  typedef struct {
    logic [1:0]  aluop;
    logic [3:0]  func;
    logic [31:0] a, b;
    logic [3:0]  ctl;
    logic        err;
    logic [31:0] data;
    logic        zero;
  } vec_t;
  vec_t v[11];
  logic g[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive0(input logic vld, input logic [1:0] op, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = vld; bus.req0_aluop = op; bus.req0_func = fn; bus.req0_a = a; bus.req0_b = b;
  endtask
  task automatic drive1(input logic vld, input logic [1:0] op, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.req1_valid = vld; bus.req1_aluop = op; bus.req1_func = fn; bus.req1_a = a; bus.req1_b = b;
  endtask
  initial begin
    v[0]  = '{2'b10, 4'b0000, 32'd5,          32'd7,    4'b0010, 1'b0, 32'd12,  1'b0};
    v[1]  = '{2'b01, 4'b1111, 32'd9,          32'd9,    4'b0110, 1'b0, 32'd0,   1'b1};
    v[2]  = '{2'b00, 4'b0101, 32'd3,          32'd4,    4'b0010, 1'b0, 32'd7,   1'b0};
    v[3]  = '{2'b10, 4'b1000, 32'd10,         32'd3,    4'b0110, 1'b0, 32'd7,   1'b0};
    v[4]  = '{2'b10, 4'b0111, 32'hF0,         32'h3C,   4'b0000, 1'b0, 32'h30,  1'b0};
    v[5]  = '{2'b10, 4'b0110, 32'hF0,         32'h0F,   4'b0001, 1'b0, 32'hFF,  1'b0};
    v[6]  = '{2'b10, 4'b1100, 32'hFFFF_FFFF,  32'd1,    4'b0111, 1'b0, 32'd1,   1'b0};
    v[7]  = '{2'b10, 4'b1100, 32'd5,          32'd2,    4'b0111, 1'b0, 32'd0,   1'b1};
    v[8]  = '{2'b10, 4'b0101, 32'd1,          32'd2,    4'b0111, 1'b1, 32'd0,   1'b0};
    v[9]  = '{2'b11, 4'b0000, 32'd1,          32'd1,    4'b0010, 1'b0, 32'd2,   1'b0};
    v[10] = '{2'b10, 4'b1111, 32'd0,          32'd0,    4'b0010, 1'b1, 32'd0,   1'b0};
    drive0(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    drive1(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    bus.flush = 1'b0;
    #1;
    chk("rst_alu_ctl", 32'(bus.alu_ctl), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    // reset arriving between grant and response
    drive0(1'b1, 2'b10, 4'b0000, 32'd5, 32'd7);
    tick();
    chk("midrst_issued_ctl", 32'(bus.alu_ctl), 32'b0010);
    drive0(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_alu_ctl", 32'(bus.alu_ctl), 32'd0);
    chk("midrst_alu_a", bus.alu_a, 32'd0);
    chk("midrst_alu_b", bus.alu_b, 32'd0);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("midrst_no_stale", 32'(bus.resp_valid), 32'd0);
    tick();
    chk("midrst_no_stale2", 32'(bus.resp_valid), 32'd0);
    for (int i = 0; i < 11; i++) begin
      drive0(1'b1, v[i].aluop, v[i].func, v[i].a, v[i].b);
      #1;
      chk($sformatf("v%0d_ready0", i), 32'(bus.req0_ready), 32'd1);
      chk($sformatf("v%0d_ready1", i), 32'(bus.req1_ready), 32'd0);
      tick();
      chk($sformatf("v%0d_alu_ctl", i), 32'(bus.alu_ctl), 32'(v[i].ctl));
      chk($sformatf("v%0d_early_resp", i), 32'(bus.resp_valid), 32'd0);
      drive0(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
      tick();
      chk($sformatf("v%0d_resp_valid", i), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("v%0d_resp_id", i), 32'(bus.resp_id), 32'd0);
      chk($sformatf("v%0d_resp_data", i), bus.resp_data, v[i].data);
      chk($sformatf("v%0d_resp_zero", i), 32'(bus.resp_zero), 32'(v[i].zero));
      chk($sformatf("v%0d_resp_err", i), 32'(bus.resp_err), 32'(v[i].err));
      tick();
      chk($sformatf("v%0d_pulse_end", i), 32'(bus.resp_valid), 32'd0);
    end
    // back-to-back port 0 sub then port 1 and
    drive0(1'b1, 2'b01, 4'b0000, 32'd9, 32'd9);
    tick();
    chk("b2b_ctl0", 32'(bus.alu_ctl), 32'b0110);
    drive0(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    drive1(1'b1, 2'b10, 4'b0111, 32'hF0, 32'h0F);
    #1;
    chk("b2b_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    chk("b2b_ctl1", 32'(bus.alu_ctl), 32'b0000);
    chk("b2b_r0_valid", 32'(bus.resp_valid), 32'd1);
    chk("b2b_r0_id", 32'(bus.resp_id), 32'd0);
    chk("b2b_r0_data", bus.resp_data, 32'd0);
    chk("b2b_r0_zero", 32'(bus.resp_zero), 32'd1);
    drive1(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    tick();
    chk("b2b_r1_valid", 32'(bus.resp_valid), 32'd1);
    chk("b2b_r1_id", 32'(bus.resp_id), 32'd1);
    chk("b2b_r1_data", bus.resp_data, 32'd0);
    chk("b2b_r1_zero", 32'(bus.resp_zero), 32'd1);
    tick();
    // starvation: both ports requesting for eight cycles
    drive0(1'b1, 2'b00, 4'b0000, 32'd1, 32'd1);
    drive1(1'b1, 2'b00, 4'b0000, 32'd100, 32'd1);
    for (int i = 0; i < 8; i++) begin
      #1;
      g[i] = bus.req1_ready;
      chk($sformatf("starve%0d_ready1", i), 32'(bus.req1_ready), 32'(i % 4 == 3));
      chk($sformatf("starve%0d_ready0", i), 32'(bus.req0_ready), 32'(i % 4 != 3));
      tick();
      if (i > 0) begin
        chk($sformatf("starve%0d_resp_valid", i), 32'(bus.resp_valid), 32'd1);
        chk($sformatf("starve%0d_resp_id", i), 32'(bus.resp_id), 32'((i - 1) % 4 == 3));
      end
    end
    drive0(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    drive1(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    tick();
    chk("starve_last_id", 32'(bus.resp_id), 32'd1);
    chk("starve_last_data", bus.resp_data, 32'd101);
    tick();
    // flush kills port-0 op in stage 1, port-1 grant proceeds
    drive0(1'b1, 2'b00, 4'b0000, 32'd1, 32'd1);
    tick();
    drive0(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    drive1(1'b1, 2'b00, 4'b0000, 32'd2, 32'd3);
    bus.flush = 1'b1;
    tick();
    chk("flush_p0_dropped", 32'(bus.resp_valid), 32'd0);
    bus.flush = 1'b0;
    drive1(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    tick();
    chk("flush_p1_valid", 32'(bus.resp_valid), 32'd1);
    chk("flush_p1_id", 32'(bus.resp_id), 32'd1);
    chk("flush_p1_data", bus.resp_data, 32'd5);
    // port-0 grant during flush is consumed but not issued
    drive0(1'b1, 2'b01, 4'b0000, 32'd8, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.flush = 1'b0;
    drive0(1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
    chk("flush_ctl_held", 32'(bus.alu_ctl), 32'b0010);
    chk("flush_a_held", bus.alu_a, 32'd2);
    tick();
    chk("flush_no_resp", 32'(bus.resp_valid), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single execute-stage ALU between two requesters: port 0 (pipeline EX stage) and port 1 (auxiliary unit, e.g. branch-target/debug compare). Per request it arbitrates, decodes ALUOp/FuncCode into the 4-bit ALU control code, registers the operands and control onto the ALU inputs, and captures the ALU result into a tagged response. It is a two-stage pipeline: grant, then issue/capture. It sits between the EX-stage operand muxes and the combinational ALU.

Parameters:
WIDTH, 32, operand/result width in bits
STARVE_LIMIT, 3, number of consecutive lost arbitration cycles after which port 1 overrides port 0 (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request
req0_ready  out  1  port 0 granted this cycle (combinational)
req0_aluop  in  2  port 0 ALUOp
req0_func  in  4  port 0 FuncCode {IR[30], funct3}
req0_a, req0_b  in  WIDTH  port 0 operands
req1_valid, req1_ready, req1_aluop, req1_func, req1_a, req1_b  same as port 0, for port 1
flush  in  1  kill all in-flight port-0 operations
alu_ctl  out  4  registered ALU control code
alu_a, alu_b  out  WIDTH  registered ALU operands
alu_result  in  WIDTH  combinational ALU result for the current alu_ctl/a/b
alu_zero  in  1  ALU zero flag
resp_valid  out  1  response valid, one cycle pulse
resp_id  out  1  requester that owns the response
resp_data  out  WIDTH  captured result
resp_zero  out  1  captured zero flag
resp_err  out  1  illegal encoding; resp_data=0, resp_zero=0

Behaviour:
- Reset (async, rst_n=0): alu_ctl=4'b0000, alu_a=alu_b=0, issue_valid=0, resp_valid=0, resp_id=0, resp_data=0, resp_zero=0, resp_err=0, starve counter=0. Ready outputs follow the arbitration rule at all times. Deassertion mid-operation discards everything in flight; no stale response is ever emitted.
- Arbitration (combinational, every cycle). override = req1_valid && cnt >= STARVE_LIMIT.
  - req1_ready = req1_valid && (!req0_valid || override).
  - req0_ready = req0_valid && !override.
  - At most one ready is high. No backpressure: a grant always issues.
- Starve counter (4 bits, saturating at 15): clears when req1_valid=0 or req1 is granted; increments when req1_valid && !req1_ready.
  - With STARVE_LIMIT=3 and both ports requesting continuously: grants are 0,0,0,1,0,0,0,1,...
- Decode (granted request only):
  - ALUOp=00 -> 0010.
  - ALUOp=01 -> 0110.
  - ALUOp=1x -> FuncCode 0000->0010 (add), 1000->0110 (sub), 0111->0000 (and), 0110->0001 (or), 1100->0111 (blt).
  - Any other FuncCode -> illegal: err bit set, alu_ctl is held at its previous value.
- Stage 1 (edge E): on a grant, register alu_ctl, alu_a, alu_b, issue_valid=1, issue_id, issue_err. With no grant, issue_valid=0 and alu_ctl/a/b hold their values (no toggling).
- Stage 2 (edge E+1): if issue_valid, capture resp_data=alu_result and resp_zero=alu_zero (both 0 if err), plus resp_id and resp_err; resp_valid=1 for exactly one cycle.
- Timing: latency is 2 edges from grant to resp_valid high. Throughput is 1 per cycle, with responses in grant order.
- Flush: while flush=1 at an edge:
  - a stage-1 op with id 0 is dropped (issue_valid cleared);
  - a port-0 grant in that same cycle is not issued (req0_ready still reflects arbitration, and the request is consumed and discarded);
  - port-1 ops are unaffected;
  - a response already in stage 2 still completes.
- Simultaneous flush and starvation override: port 1 issues normally.

Test Plan:
- Reset mid-op: grant port 0 (add, 5+7), assert rst_n=0 before the response edge -> resp_valid stays 0, all outputs return to reset values asynchronously.
- Single port-0 add: ALUOp=10, func=0000, a=5, b=7, ALU model returns 12 -> alu_ctl=0010 one edge after grant; resp_valid=1, id=0, data=12, zero=0 two edges after grant.
- Back-to-back mixed traffic: port 0 sub (9-9, aluop=01) followed by port 1 and (0xF0 & 0x0F) -> alu_ctl 0110 then 0000; responses in order (id0 data=0 zero=1), then (id1 data=0 zero=1).
- Starvation: both ports valid for 8 cycles, STARVE_LIMIT=3 -> grant sequence 0,0,0,1,0,0,0,1; counter clears on each port-1 grant.
- Illegal encoding: ALUOp=10, func=0101 -> resp_err=1, data=0, alu_ctl unchanged; next legal op decodes normally.
- Flush: port-0 op in stage 1, port-1 op granted, flush=1 for one cycle -> port-0 response suppressed, port-1 response delivered two edges after its grant.
